// File: rtl/data_provider_pkg.sv
// Shared types and constants for the data_provider AXI4-Stream generator.
// Build option: DATA_PROVIDER_LFSR_EN selects the LFSR data source in data_provider_axis_gen.
package data_provider_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;

  // Right-shift Galois mask for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } gen_state_e;

endpackage

// File: rtl/data_provider_axis_reg.sv
// Single-entry AXI4-Stream output register slice holding TDATA/TLAST/TVALID.
// The owner only asserts load when the slice is empty or handshaking this cycle.
module data_provider_axis_reg
  import data_provider_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  // Load wins over drain so back-to-back beats sustain one per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/data_provider_axis_gen.sv
// Burst generator: emits cfg_len words (seed + k*step) on an AXI4-Stream master.
// Build option: define DATA_PROVIDER_LFSR_EN to source words from a Galois LFSR instead.
module data_provider_axis_gen
  import data_provider_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  stat_busy,
  output logic                  stat_done,
  output logic [LEN_WIDTH-1:0]  stat_beats
);

  gen_state_e state, state_next;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  beats;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] first_word;
  logic [DATA_WIDTH-1:0] first_succ;
  logic [DATA_WIDTH-1:0] acc_succ;
  logic                  handshake;
  logic                  accept_start;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;

`ifdef DATA_PROVIDER_LFSR_EN
  function automatic logic [DATA_WIDTH-1:0] lfsr_adv(input logic [DATA_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? DATA_WIDTH'(LFSR_TAPS) : '0);
  endfunction

  // A zero seed would lock the LFSR at zero forever
  always_comb begin
    first_word = (cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;
    first_succ = lfsr_adv(first_word);
    acc_succ   = lfsr_adv(acc);
  end
`else
  logic [DATA_WIDTH-1:0] step_q;

  always_comb begin
    first_word = cfg_seed;
    first_succ = cfg_seed + cfg_step;
    acc_succ   = acc + step_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)          step_q <= '0;
    else if (accept_start) step_q <= cfg_step;
  end
`endif

  assign handshake    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign accept_start = (state == IDLE) && cfg_start;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  // acc always holds the word for index 'issued', ready to refill the slice
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_data  = acc;
    load_last  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            state_next = STREAM;
            load       = 1'b1;
            load_data  = first_word;
            load_last  = (cfg_len == LEN_WIDTH'(1));
          end else begin
            state_next = DONE;
          end
        end
      end
      STREAM: begin
        if (handshake) begin
          if (M_AXIS_TLAST) begin
            state_next = DONE;
          end else begin
            load      = 1'b1;
            load_data = acc;
            load_last = (issued == len_q - LEN_WIDTH'(1));
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      len_q  <= '0;
      issued <= '0;
      beats  <= '0;
      acc    <= '0;
    end else if (accept_start) begin
      len_q  <= cfg_len;
      issued <= LEN_WIDTH'(1);
      beats  <= '0;
      acc    <= first_succ;
    end else if (state == STREAM && handshake) begin
      beats <= beats + LEN_WIDTH'(1);
      if (load) begin
        issued <= issued + LEN_WIDTH'(1);
        acc    <= acc_succ;
      end
    end
  end

  data_provider_axis_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .load     (load),
    .load_data(load_data),
    .load_last(load_last),
    .ready    (M_AXIS_TREADY),
    .valid    (M_AXIS_TVALID),
    .data     (M_AXIS_TDATA),
    .last     (M_AXIS_TLAST)
  );

  assign stat_busy  = (state != IDLE);
  assign stat_done  = (state == DONE);
  assign stat_beats = beats;

endmodule
